// File: rtl/rect_plot_arbiter_if.sv
// Request/grant bundle between the drawing clients (snake, apple, eraser) and
// the rectangle plot arbiter. Fields are packed per requester, requester 0 in the LSBs.
interface rect_plot_arbiter_if;
  logic [2:0]  req;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [11:0] req_w;
  logic [11:0] req_h;
  logic [8:0]  req_colour;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic        busy;

  modport master (
    output req, req_x, req_y, req_w, req_h, req_colour,
    input  gnt, done, busy
  );

  modport slave (
    input  req, req_x, req_y, req_w, req_h, req_colour,
    output gnt, done, busy
  );
endinterface

// File: rtl/rect_plot_arbiter.sv
// Round-robin arbiter that rasterises one requester's filled rectangle at a time
// onto the vga_adapter pixel-write port, one pixel per clock, clipped to the screen.
module rect_plot_arbiter #(
  parameter int XSCREEN = 160,
  parameter int YSCREEN = 120
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  rect_plot_arbiter_if.slave   bus,
  output logic [7:0]           VGA_X,
  output logic [6:0]           VGA_Y,
  output logic [2:0]           VGA_COLOR,
  output logic                 plot
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t     state;
  logic [1:0] p;
  logic [7:0] x_l;
  logic [6:0] y_l;
  logic [3:0] w_l, h_l;
  logic [2:0] c_l;
  logic [3:0] xc, yc;

  logic       found;
  logic [1:0] sel, cand;
  logic [7:0] sel_x;
  logic [6:0] sel_y;
  logic [3:0] sel_w, sel_h;
  logic [2:0] sel_c;
  logic       col_end, row_end;
  logic [3:0] nxt_xc, nxt_yc;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [3:0] off_x, off_y;
  logic [8:0] px;
  logic [7:0] py;
  logic       in_screen;

  // Round-robin search starting at p; first requesting index wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      cand = 2'((32'(p) + k) % 3);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    case (sel)
      2'd1: begin
        sel_x = bus.req_x[15:8];   sel_y = bus.req_y[13:7];
        sel_w = bus.req_w[7:4];    sel_h = bus.req_h[7:4];
        sel_c = bus.req_colour[5:3];
      end
      2'd2: begin
        sel_x = bus.req_x[23:16];  sel_y = bus.req_y[20:14];
        sel_w = bus.req_w[11:8];   sel_h = bus.req_h[11:8];
        sel_c = bus.req_colour[8:6];
      end
      default: begin
        sel_x = bus.req_x[7:0];    sel_y = bus.req_y[6:0];
        sel_w = bus.req_w[3:0];    sel_h = bus.req_h[3:0];
        sel_c = bus.req_colour[2:0];
      end
    endcase
  end

  // Outputs are registered, so the coordinate computed here is for the pixel
  // shown in the next cycle: origin on the grant edge, advanced counters in DRAW.
  always_comb begin
    col_end   = (xc == w_l - 4'd1);
    row_end   = (yc == h_l - 4'd1);
    nxt_xc    = col_end ? 4'd0 : xc + 4'd1;
    nxt_yc    = col_end ? yc + 4'd1 : yc;
    base_x    = (state == IDLE) ? sel_x : x_l;
    base_y    = (state == IDLE) ? sel_y : y_l;
    off_x     = (state == IDLE) ? 4'd0 : nxt_xc;
    off_y     = (state == IDLE) ? 4'd0 : nxt_yc;
    px        = {1'b0, base_x} + {5'b0, off_x};
    py        = {1'b0, base_y} + {4'b0, off_y};
    in_screen = (px < 9'(XSCREEN)) && (py < 8'(YSCREEN));
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      p         <= '0;
      x_l       <= '0;
      y_l       <= '0;
      w_l       <= '0;
      h_l       <= '0;
      c_l       <= '0;
      xc        <= '0;
      yc        <= '0;
      bus.gnt   <= '0;
      bus.done  <= '0;
      bus.busy  <= 1'b0;
      plot      <= 1'b0;
      VGA_X     <= '0;
      VGA_Y     <= '0;
      VGA_COLOR <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            x_l      <= sel_x;
            y_l      <= sel_y;
            w_l      <= sel_w;
            h_l      <= sel_h;
            c_l      <= sel_c;
            xc       <= '0;
            yc       <= '0;
            p        <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
            bus.gnt  <= 3'b001 << sel;
            bus.busy <= 1'b1;
            if (sel_w == 4'd0 || sel_h == 4'd0) begin
              state    <= DONE;
              bus.done <= 3'b001 << sel;
            end else begin
              state     <= DRAW;
              plot      <= in_screen;
              VGA_X     <= px[7:0];
              VGA_Y     <= py[6:0];
              VGA_COLOR <= sel_c;
            end
          end
        end
        DRAW: begin
          if (col_end && row_end) begin
            state     <= DONE;
            bus.done  <= bus.gnt;
            plot      <= 1'b0;
            VGA_X     <= '0;
            VGA_Y     <= '0;
            VGA_COLOR <= '0;
          end else begin
            xc        <= nxt_xc;
            yc        <= nxt_yc;
            plot      <= in_screen;
            VGA_X     <= px[7:0];
            VGA_Y     <= py[6:0];
            VGA_COLOR <= c_l;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= '0;
          bus.gnt  <= '0;
          bus.busy <= 1'b0;
          xc       <= '0;
          yc       <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_plot_arbiter.sv
// Directed bench for rect_plot_arbiter: single draw, contention, clipping,
// empty rectangle, reset mid-draw and request changes mid-draw.
module tb_rect_plot_arbiter;
  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic [7:0] VGA_X;
  logic [6:0] VGA_Y;
  logic [2:0] VGA_COLOR;
  logic       plot;

  int n_checks = 0;
  int n_fail   = 0;

  rect_plot_arbiter_if bus();

  rect_plot_arbiter #(.XSCREEN(160), .YSCREEN(120)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .bus      (bus),
    .VGA_X    (VGA_X),
    .VGA_Y    (VGA_Y),
    .VGA_COLOR(VGA_COLOR),
    .plot     (plot)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic set_req(input int i, input logic [7:0] x, input logic [6:0] y,
                         input logic [3:0] w, input logic [3:0] h, input logic [2:0] c);
    bus.req_x[i*8 +: 8]      = x;
    bus.req_y[i*7 +: 7]      = y;
    bus.req_w[i*4 +: 4]      = w;
    bus.req_h[i*4 +: 4]      = h;
    bus.req_colour[i*3 +: 3] = c;
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    resetn = 1'b0;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (bus.gnt !== 3'b000 || bus.done !== 3'b000 || bus.busy !== 1'b0 || plot !== 1'b0 ||
        VGA_X !== 8'd0 || VGA_Y !== 7'd0 || VGA_COLOR !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: got gnt=%b done=%b busy=%b plot=%b x=%0d y=%0d c=%0d, want all zero",
               bus.gnt, bus.done, bus.busy, plot, VGA_X, VGA_Y, VGA_COLOR);
    end
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    @(negedge CLOCK_50);
    n_checks++;
    if (bus.gnt !== 3'b000 || bus.busy !== 1'b0 || plot !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got gnt=%b busy=%b plot=%b, want 000 0 0", bus.gnt, bus.busy, plot);
    end
  endtask

  task automatic test_single();
    int ex[6] = '{10, 11, 12, 10, 11, 12};
    int ey[6] = '{20, 20, 20, 21, 21, 21};
    set_req(0, 8'd10, 7'd20, 4'd3, 4'd2, 3'd5);
    bus.req = 3'b001;
    @(negedge CLOCK_50);
    bus.req = 3'b000;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (plot !== 1'b1 || VGA_X !== 8'(ex[i]) || VGA_Y !== 7'(ey[i]) || VGA_COLOR !== 3'd5 ||
          bus.gnt !== 3'b001 || bus.busy !== 1'b1 || bus.done !== 3'b000) begin
        n_fail++;
        $display("FAIL single_px%0d: got plot=%b x=%0d y=%0d c=%0d gnt=%b busy=%b done=%b, want plot=1 x=%0d y=%0d c=5 gnt=001 busy=1 done=000",
                 i, plot, VGA_X, VGA_Y, VGA_COLOR, bus.gnt, bus.busy, bus.done, ex[i], ey[i]);
      end
      @(negedge CLOCK_50);
    end
    n_checks++;
    if (bus.done !== 3'b001 || bus.gnt !== 3'b001 || bus.busy !== 1'b1 || plot !== 1'b0 || VGA_X !== 8'd0) begin
      n_fail++;
      $display("FAIL single_done: got done=%b gnt=%b busy=%b plot=%b x=%0d, want 001 001 1 0 0",
               bus.done, bus.gnt, bus.busy, plot, VGA_X);
    end
    @(negedge CLOCK_50);
    n_checks++;
    if (bus.done !== 3'b000 || bus.gnt !== 3'b000 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: got done=%b gnt=%b busy=%b, want 000 000 0", bus.done, bus.gnt, bus.busy);
    end
  endtask

  task automatic test_contention();
    int order[4] = '{0, 0, 0, 0};
    int ng = 0;
    logic [2:0] prev = 3'b000;
    do_reset();
    for (int i = 0; i < 3; i++) set_req(i, 8'(i), 7'(i), 4'd1, 4'd1, 3'(i + 1));
    bus.req = 3'b111;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      @(negedge CLOCK_50);
      n_checks++;
      if ((bus.gnt & (bus.gnt - 3'b001)) !== 3'b000) begin
        n_fail++;
        $display("FAIL contention_onehot: got gnt=%b, want at most one bit", bus.gnt);
      end
      if (bus.done !== 3'b000) begin
        n_checks++;
        if (bus.done !== bus.gnt) begin
          n_fail++;
          $display("FAIL contention_done: got done=%b, want done=gnt=%b", bus.done, bus.gnt);
        end
      end
      if (prev === 3'b000 && bus.gnt !== 3'b000) begin
        for (int b = 0; b < 3; b++) if (bus.gnt[b]) order[ng] = b;
        ng++;
      end
      prev = bus.gnt;
    end
    n_checks++;
    if (ng != 4 || order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 0) begin
      n_fail++;
      $display("FAIL contention_order: got %0d grants order %0d %0d %0d %0d, want 4 grants order 0 1 2 0",
               ng, order[0], order[1], order[2], order[3]);
    end
    bus.req = 3'b000;
    do_reset();
  endtask

  task automatic test_clip();
    int draw_cnt = 0, plot_cnt = 0, bad = 0;
    logic got_done = 1'b0;
    logic [2:0] done_val = 3'b000;
    set_req(1, 8'd155, 7'd118, 4'd10, 4'd4, 3'd3);
    bus.req = 3'b010;
    for (int c = 0; c < 100 && !got_done; c++) begin
      @(negedge CLOCK_50);
      bus.req = 3'b000;
      if (bus.done !== 3'b000) begin
        got_done = 1'b1;
        done_val = bus.done;
      end else if (bus.gnt !== 3'b000) begin
        draw_cnt++;
        if (plot === 1'b1) begin
          plot_cnt++;
          if (VGA_X < 8'd155 || VGA_X > 8'd159 || VGA_Y < 7'd118 || VGA_Y > 7'd119) bad++;
        end
      end
    end
    n_checks++;
    if (draw_cnt != 40) begin
      n_fail++;
      $display("FAIL clip_draw_cycles: got %0d, want 40", draw_cnt);
    end
    n_checks++;
    if (plot_cnt != 10 || bad != 0) begin
      n_fail++;
      $display("FAIL clip_plots: got %0d plots (%0d off-screen), want 10 (0)", plot_cnt, bad);
    end
    n_checks++;
    if (!got_done || done_val !== 3'b010) begin
      n_fail++;
      $display("FAIL clip_done: got seen=%b done=%b, want seen=1 done=010", got_done, done_val);
    end
    @(negedge CLOCK_50);
  endtask

  task automatic test_empty();
    set_req(2, 8'd0, 7'd0, 4'd0, 4'd5, 3'd7);
    bus.req = 3'b100;
    @(negedge CLOCK_50);
    bus.req = 3'b000;
    n_checks++;
    if (bus.done !== 3'b100 || bus.gnt !== 3'b100 || bus.busy !== 1'b1 || plot !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_done: got done=%b gnt=%b busy=%b plot=%b, want 100 100 1 0",
               bus.done, bus.gnt, bus.busy, plot);
    end
    @(negedge CLOCK_50);
    n_checks++;
    if (bus.done !== 3'b000 || bus.busy !== 1'b0 || plot !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_idle: got done=%b busy=%b plot=%b, want 000 0 0", bus.done, bus.busy, plot);
    end
  endtask

  task automatic test_reset_mid_draw();
    logic done_seen = 1'b0;
    do_reset();
    set_req(0, 8'd0, 7'd0, 4'd10, 4'd10, 3'd1);
    bus.req = 3'b001;
    @(negedge CLOCK_50);
    repeat (4) @(negedge CLOCK_50);
    n_checks++;
    if (plot !== 1'b1 || VGA_X !== 8'd4 || VGA_Y !== 7'd0 || bus.gnt !== 3'b001) begin
      n_fail++;
      $display("FAIL rstmid_px4: got plot=%b x=%0d y=%0d gnt=%b, want 1 4 0 001", plot, VGA_X, VGA_Y, bus.gnt);
    end
    #1 resetn = 1'b0;
    #1;
    n_checks++;
    if (plot !== 1'b0 || bus.gnt !== 3'b000 || bus.busy !== 1'b0 || bus.done !== 3'b000) begin
      n_fail++;
      $display("FAIL rstmid_async: got plot=%b gnt=%b busy=%b done=%b, want 0 000 0 000",
               plot, bus.gnt, bus.busy, bus.done);
    end
    repeat (3) begin
      @(negedge CLOCK_50);
      if (bus.done !== 3'b000) done_seen = 1'b1;
    end
    for (int i = 0; i < 3; i++) set_req(i, 8'd1, 7'd1, 4'd1, 4'd1, 3'd2);
    bus.req = 3'b111;
    resetn  = 1'b1;
    @(negedge CLOCK_50);
    if (bus.done !== 3'b000) done_seen = 1'b1;
    n_checks++;
    if (done_seen) begin
      n_fail++;
      $display("FAIL rstmid_no_done: got done pulse=1, want 0");
    end
    n_checks++;
    if (bus.gnt !== 3'b001) begin
      n_fail++;
      $display("FAIL rstmid_priority: got gnt=%b, want 001", bus.gnt);
    end
    bus.req = 3'b000;
    do_reset();
  endtask

  task automatic test_input_change();
    int ex[4] = '{50, 51, 50, 51};
    int ey[4] = '{60, 60, 61, 61};
    set_req(0, 8'd50, 7'd60, 4'd2, 4'd2, 3'd6);
    bus.req = 3'b001;
    @(negedge CLOCK_50);
    bus.req        = 3'b000;
    bus.req_x      = '1;
    bus.req_y      = '1;
    bus.req_w      = '1;
    bus.req_colour = '0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (plot !== 1'b1 || VGA_X !== 8'(ex[i]) || VGA_Y !== 7'(ey[i]) || VGA_COLOR !== 3'd6) begin
        n_fail++;
        $display("FAIL change_px%0d: got plot=%b x=%0d y=%0d c=%0d, want plot=1 x=%0d y=%0d c=6",
                 i, plot, VGA_X, VGA_Y, VGA_COLOR, ex[i], ey[i]);
      end
      @(negedge CLOCK_50);
    end
    n_checks++;
    if (bus.done !== 3'b001) begin
      n_fail++;
      $display("FAIL change_done: got done=%b, want 001", bus.done);
    end
    @(negedge CLOCK_50);
  endtask

  initial begin
    bus.req        = '0;
    bus.req_x      = '0;
    bus.req_y      = '0;
    bus.req_w      = '0;
    bus.req_h      = '0;
    bus.req_colour = '0;
    test_reset();
    test_single();
    test_contention();
    test_clip();
    test_empty();
    test_reset_mid_draw();
    test_input_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
